// File: rtl/logic_op_ctrl_if.sv
// Operand/enable bus to the logic units plus the downstream result handshake.
// The controller uses the master view; the units and result sink use the slave view.
interface logic_op_ctrl_if;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] z;
    logic [3:0] unit_en;
    logic [3:0] and_out;
    logic [3:0] or_out;
    logic [3:0] xor_out;
    logic [7:0] not_out;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ready;

    modport master (
        output x, y, z, unit_en, result, result_valid,
        input  and_out, or_out, xor_out, not_out, result_ready
    );

    modport slave (
        input  x, y, z, unit_en, result, result_valid,
        output and_out, or_out, xor_out, not_out, result_ready
    );
endinterface

// File: rtl/logic_op_ctrl.sv
// Switch/key front-end for the AND/OR/XOR/NOT logic units: captures operands on
// key presses, enables one unit for a single cycle and hands the result downstream.
module logic_op_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           sw,
    input  logic [1:0]           op_sel,
    input  logic                 key_enter,
    input  logic                 cancel,
    logic_op_ctrl_if.master      bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GET_B = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOT = 2'b11;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_prev_q;
    logic                   enter_pulse;
    logic [1:0]             op_q;
    logic [3:0]             x_q;
    logic [3:0]             y_q;
    logic [7:0]             z_q;
    logic [3:0]             unit_en_q;
    logic [7:0]             result_q;
    logic [7:0]             result_d;
    logic                   result_valid_q;
    logic [CNT_W-1:0]       op_count_q;

    function automatic logic [3:0] onehot(input logic [1:0] op);
        return 4'b0001 << op;
    endfunction

    // key_enter is asynchronous; only the last stage feeds the edge detector
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= '0;
            key_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], key_enter};
            key_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign enter_pulse = sync_q[SYNC_STAGES-1] & ~key_prev_q;

    always_comb begin
        result_d = 8'h00;
        case (op_q)
            2'b00:   result_d = {4'h0, bus.and_out};
            2'b01:   result_d = {4'h0, bus.or_out};
            2'b10:   result_d = {4'h0, bus.xor_out};
            default: result_d = bus.not_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            op_q           <= 2'b00;
            x_q            <= 4'h0;
            y_q            <= 4'h0;
            z_q            <= 8'h00;
            unit_en_q      <= 4'h0;
            result_q       <= 8'h00;
            result_valid_q <= 1'b0;
            op_count_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enter_pulse) begin
                        op_q <= op_sel;
                        if (op_sel == OP_NOT) begin
                            z_q       <= sw;
                            unit_en_q <= onehot(OP_NOT);
                            state_q   <= EXEC;
                        end else begin
                            x_q     <= sw[3:0];
                            state_q <= GET_B;
                        end
                    end
                end
                GET_B: begin
                    if (cancel) begin
                        state_q <= IDLE;
                    end else if (enter_pulse) begin
                        y_q       <= sw[3:0];
                        unit_en_q <= onehot(op_q);
                        state_q   <= EXEC;
                    end
                end
                // unit_en is raised on entry so the unit output is settled by the end of EXEC
                EXEC: begin
                    unit_en_q <= 4'h0;
                    if (cancel) begin
                        state_q <= IDLE;
                    end else begin
                        result_q       <= result_d;
                        result_valid_q <= 1'b1;
                        state_q        <= DONE;
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        result_valid_q <= 1'b0;
                        op_count_q     <= op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_q        <= IDLE;
                    end else if (cancel) begin
                        result_valid_q <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.x            = x_q;
    assign bus.y            = y_q;
    assign bus.z            = z_q;
    assign bus.unit_en      = unit_en_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign busy             = (state_q != IDLE);
    assign op_count         = op_count_q;

endmodule

// File: tb/tb_logic_op_ctrl.sv
// Directed bench for logic_op_ctrl: vector table of complete operations plus
// hand-written sequences for held keys, cancel, reset in DONE and counter wrap.
module tb_logic_op_ctrl;

    localparam int SYNC = 2;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    sw;
    logic [1:0]    op_sel;
    logic          key_enter;
    logic          cancel;
    logic          busy;
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    logic_op_ctrl_if u_if ();

    // Behavioural logic units; outputs are gated by their enable
    assign u_if.and_out = u_if.unit_en[0] ? (u_if.x & u_if.y) : 4'h0;
    assign u_if.or_out  = u_if.unit_en[1] ? (u_if.x | u_if.y) : 4'h0;
    assign u_if.xor_out = u_if.unit_en[2] ? (u_if.x ^ u_if.y) : 4'h0;
    assign u_if.not_out = u_if.unit_en[3] ? ~u_if.z : 8'h00;

    logic_op_ctrl #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .op_sel   (op_sel),
        .key_enter(key_enter),
        .cancel   (cancel),
        .bus      (u_if.master),
        .busy     (busy),
        .op_count (op_count)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int en_cnt = 0;
    int exec_cyc = -1;
    int valid_cyc = -1;
    int press_cyc = 0;
    int exp_count = 0;
    logic [3:0] en_seen = 4'h0;
    logic valid_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.unit_en != 4'h0) begin
            en_cnt   = en_cnt + 1;
            en_seen  = u_if.unit_en;
            exec_cyc = cyc;
        end
        if (u_if.result_valid && !valid_prev) valid_cyc = cyc;
        valid_prev = u_if.result_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [7:0] v, input int hold);
        sw        = v;
        key_enter = 1'b1;
        press_cyc = cyc;
        repeat (hold) @(negedge clk);
        key_enter = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
    endtask

    task automatic run_op(input logic [1:0] op1, input logic [1:0] op2,
                          input logic [7:0] a, input logic [7:0] b, input int hold);
        op_sel    = op1;
        en_cnt    = 0;
        en_seen   = 4'h0;
        exec_cyc  = -1;
        valid_cyc = -1;
        press(a, hold);
        if (op1 != 2'b11) begin
            op_sel = op2;
            press(b, hold);
        end
    endtask

    task automatic handshake(input int delay, input logic with_cancel);
        logic       ok;
        logic [7:0] r0;
        ok = 1'b1;
        r0 = u_if.result;
        repeat (delay) begin
            @(negedge clk);
            if (u_if.result !== r0 || u_if.result_valid !== 1'b1) ok = 1'b0;
        end
        if (delay > 0) chk("hold_stable", {31'd0, ok}, 32'd1);
        u_if.result_ready = 1'b1;
        cancel            = with_cancel;
        @(negedge clk);
        u_if.result_ready = 1'b0;
        cancel            = 1'b0;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] en;
        logic [7:0] res;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] r_prev;
        logic [3:0] wa;
        logic [3:0] wb;

        vecs[0] = '{2'b00, 8'hBC, 8'h7A, 4'b0001, 8'h08};
        vecs[1] = '{2'b01, 8'h0C, 8'h0A, 4'b0010, 8'h0E};
        vecs[2] = '{2'b10, 8'h19, 8'h23, 4'b0100, 8'h0A};
        vecs[3] = '{2'b11, 8'hA5, 8'h00, 4'b1000, 8'h5A};
        vecs[4] = '{2'b00, 8'h5F, 8'hAF, 4'b0001, 8'h0F};
        vecs[5] = '{2'b01, 8'hF0, 8'hF0, 4'b0010, 8'h00};
        vecs[6] = '{2'b10, 8'h37, 8'h8E, 4'b0100, 8'h09};
        vecs[7] = '{2'b11, 8'h00, 8'h00, 4'b1000, 8'hFF};
        vecs[8] = '{2'b11, 8'hFF, 8'h00, 4'b1000, 8'h00};

        rst_n = 1'b0; sw = 8'h00; op_sel = 2'b00; key_enter = 1'b0; cancel = 1'b0;
        u_if.result_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_x", {28'd0, u_if.x}, 32'd0);
        chk("rst_z", {24'd0, u_if.z}, 32'd0);
        chk("rst_result", {24'd0, u_if.result}, 32'd0);
        chk("rst_valid", {31'd0, u_if.result_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {24'd0, op_count}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].op, vecs[i].a, vecs[i].b, 3);
            chk($sformatf("v%0d_result", i), {24'd0, u_if.result}, {24'd0, vecs[i].res});
            chk($sformatf("v%0d_valid", i), {31'd0, u_if.result_valid}, 32'd1);
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            chk($sformatf("v%0d_unit_en", i), {28'd0, en_seen}, {28'd0, vecs[i].en});
            chk($sformatf("v%0d_en_cycles", i), en_cnt, 32'd1);
            chk($sformatf("v%0d_exec_lat", i), exec_cyc - (press_cyc + SYNC), 32'd1);
            chk($sformatf("v%0d_valid_lat", i), valid_cyc - (press_cyc + SYNC), 32'd2);
            if (vecs[i].op == 2'b11)
                chk($sformatf("v%0d_z", i), {24'd0, u_if.z}, {24'd0, vecs[i].a});
            else begin
                chk($sformatf("v%0d_x", i), {28'd0, u_if.x}, {28'd0, vecs[i].a[3:0]});
                chk($sformatf("v%0d_y", i), {28'd0, u_if.y}, {28'd0, vecs[i].b[3:0]});
            end
            handshake((vecs[i].op == 2'b11) ? 10 : i, 1'b0);
            exp_count++;
            chk($sformatf("v%0d_count", i), {24'd0, op_count}, exp_count);
            chk($sformatf("v%0d_valid_clr", i), {31'd0, u_if.result_valid}, 32'd0);
            chk($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d_result_kept", i), {24'd0, u_if.result}, {24'd0, vecs[i].res});
        end

        // op_sel change between presses must not alter the latched opcode
        run_op(2'b10, 2'b01, 8'h09, 8'h03, 3);
        chk("xor_retained", {24'd0, u_if.result}, 32'h0A);
        chk("xor_retained_en", {28'd0, en_seen}, 32'h4);
        handshake(2, 1'b0);
        exp_count++;
        chk("xor_retained_count", {24'd0, op_count}, exp_count);

        // held key gives one capture; presses in DONE are dropped and not queued
        op_sel = 2'b00; en_cnt = 0;
        press(8'h03, 20);
        chk("held_getb_busy", {31'd0, busy}, 32'd1);
        chk("held_getb_noexec", en_cnt, 32'd0);
        press(8'h05, 20);
        chk("held_one_exec", en_cnt, 32'd1);
        chk("held_result", {24'd0, u_if.result}, 32'h01);
        press(8'h0F, 3);
        press(8'h0E, 3);
        chk("done_press_ignored_en", en_cnt, 32'd1);
        chk("done_press_ignored_y", {28'd0, u_if.y}, 32'h5);
        chk("done_press_valid", {31'd0, u_if.result_valid}, 32'd1);
        handshake(0, 1'b0);
        exp_count++;
        chk("held_count", {24'd0, op_count}, exp_count);
        repeat (10) @(negedge clk);
        chk("no_queued_busy", {31'd0, busy}, 32'd0);
        chk("no_queued_exec", en_cnt, 32'd1);

        // cancel in GET_B
        op_sel = 2'b01;
        press(8'h06, 3);
        chk("getb_busy", {31'd0, busy}, 32'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_getb_idle", {31'd0, busy}, 32'd0);
        chk("cancel_getb_valid", {31'd0, u_if.result_valid}, 32'd0);
        chk("cancel_getb_count", {24'd0, op_count}, exp_count);

        // cancel during the EXEC cycle
        r_prev = u_if.result;
        op_sel = 2'b00;
        press(8'h0F, 3);
        sw = 8'h03;
        key_enter = 1'b1;
        repeat (SYNC + 1) @(negedge clk);
        chk("exec_seen", {28'd0, u_if.unit_en}, 32'h1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        key_enter = 1'b0;
        chk("cancel_exec_idle", {31'd0, busy}, 32'd0);
        chk("cancel_exec_result", {24'd0, u_if.result}, {24'd0, r_prev});
        repeat (5) @(negedge clk);
        chk("cancel_exec_valid", {31'd0, u_if.result_valid}, 32'd0);
        chk("cancel_exec_count", {24'd0, op_count}, exp_count);

        // cancel in DONE without ready
        run_op(2'b01, 2'b01, 8'h05, 8'h0A, 3);
        chk("or_result", {24'd0, u_if.result}, 32'h0F);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_done_valid", {31'd0, u_if.result_valid}, 32'd0);
        chk("cancel_done_idle", {31'd0, busy}, 32'd0);
        chk("cancel_done_count", {24'd0, op_count}, exp_count);

        // cancel and ready together: handshake wins
        run_op(2'b00, 2'b00, 8'h0E, 8'h07, 3);
        chk("and_result", {24'd0, u_if.result}, 32'h06);
        handshake(1, 1'b1);
        exp_count++;
        chk("cancel_ready_count", {24'd0, op_count}, exp_count);
        chk("cancel_ready_valid", {31'd0, u_if.result_valid}, 32'd0);

        // reset while in DONE
        run_op(2'b11, 2'b11, 8'h3C, 8'h00, 3);
        chk("not_result", {24'd0, u_if.result}, 32'hC3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstdone_x", {28'd0, u_if.x}, 32'd0);
        chk("rstdone_y", {28'd0, u_if.y}, 32'd0);
        chk("rstdone_z", {24'd0, u_if.z}, 32'd0);
        chk("rstdone_unit_en", {28'd0, u_if.unit_en}, 32'd0);
        chk("rstdone_result", {24'd0, u_if.result}, 32'd0);
        chk("rstdone_valid", {31'd0, u_if.result_valid}, 32'd0);
        chk("rstdone_busy", {31'd0, busy}, 32'd0);
        chk("rstdone_count", {24'd0, op_count}, 32'd0);
        rst_n = 1'b1;
        exp_count = 0;
        repeat (2) @(negedge clk);

        // 256 back-to-back ORs wrap the counter to zero
        for (int i = 0; i < 256; i++) begin
            wa = i[3:0];
            wb = i[7:4];
            run_op(2'b01, 2'b01, {4'h0, wa}, {4'h0, wb}, 2);
            chk($sformatf("wrap%0d_result", i), {24'd0, u_if.result}, {28'd0, wa | wb});
            handshake(0, 1'b0);
            if (i == 127) chk("wrap_mid_count", {24'd0, op_count}, 32'd128);
        end
        chk("wrap_count", {24'd0, op_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
